// File: rtl/risc_pkg.sv
// Shared definitions for the small RISC control path: opcodes, FSM states,
// instruction field positions and offset sign-extension helpers.
package risc_pkg;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 11;
    localparam int RD_HI   = 10;
    localparam int RD_LO   = 8;
    localparam int RA_HI   = 7;
    localparam int RA_LO   = 5;
    localparam int RB_HI   = 4;
    localparam int RB_LO   = 2;
    localparam int IMM_HI  = 4;
    localparam int BOFF_HI = 7;
    localparam int JOFF_HI = 10;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_ADC  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_SBB  = 5'b00011;
    localparam logic [4:0] OP_ADDI = 5'b00100;
    localparam logic [4:0] OP_BZ   = 5'b01000;
    localparam logic [4:0] OP_BNZ  = 5'b01001;
    localparam logic [4:0] OP_BC   = 5'b01010;
    localparam logic [4:0] OP_BN   = 5'b01011;
    localparam logic [4:0] OP_JMP  = 5'b01100;
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    function automatic logic [31:0] sext8(input logic [7:0] x);
        return {{24{x[7]}}, x};
    endfunction

    function automatic logic [31:0] sext11(input logic [10:0] x);
        return {{21{x[10]}}, x};
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Purely combinational instruction decoder: classifies the opcode and
// extracts register fields, immediate and branch/jump offsets.
module instr_decode
    import risc_pkg::*;
(
    input  logic [15:0] instr,
    output logic [2:0]  ra,
    output logic [2:0]  rb,
    output logic [2:0]  rd,
    output logic [4:0]  imm,
    output logic        alu_op,
    output logic        addi_op,
    output logic        adc,
    output logic        sub,
    output logic        sbb,
    output logic        br_z,
    output logic        br_nz,
    output logic        br_c,
    output logic        br_n,
    output logic        jmp_op,
    output logic        halt_op,
    output logic [7:0]  br_off,
    output logic [10:0] jmp_off
);

    logic [4:0] opcode;

    assign opcode  = instr[OPC_HI:OPC_LO];
    assign br_off  = instr[BOFF_HI:0];
    assign jmp_off = instr[JOFF_HI:0];

    always_comb begin
        ra      = 3'd0;
        rb      = 3'd0;
        rd      = 3'd0;
        imm     = 5'd0;
        alu_op  = 1'b0;
        addi_op = 1'b0;
        adc     = 1'b0;
        sub     = 1'b0;
        sbb     = 1'b0;
        br_z    = 1'b0;
        br_nz   = 1'b0;
        br_c    = 1'b0;
        br_n    = 1'b0;
        jmp_op  = 1'b0;
        halt_op = 1'b0;
        case (opcode)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
                alu_op = 1'b1;
                ra     = instr[RA_HI:RA_LO];
                rb     = instr[RB_HI:RB_LO];
                rd     = instr[RD_HI:RD_LO];
                adc    = (opcode == OP_ADC);
                sub    = (opcode == OP_SUB);
                sbb    = (opcode == OP_SBB);
            end
            OP_ADDI: begin
                addi_op = 1'b1;
                ra      = instr[RA_HI:RA_LO];
                rd      = instr[RD_HI:RD_LO];
                imm     = instr[IMM_HI:0];
            end
            OP_BZ:   br_z    = 1'b1;
            OP_BNZ:  br_nz   = 1'b1;
            OP_BC:   br_c    = 1'b1;
            OP_BN:   br_n    = 1'b1;
            OP_JMP:  jmp_op  = 1'b1;
            OP_HALT: halt_op = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_fetch_decode.sv
// Single-cycle fetch/decode controller: PC, registered flags and RST/RUN/HALT FSM.
// Optional SINGLE_STEP_EN adds step_mode/step ports for edge-triggered stepping.
module ctrl_fetch_decode
    import risc_pkg::*;
#(
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [15:0]        Instr,
    input  logic               Z,
    input  logic               N,
    input  logic               C,
    input  logic               V,
`ifdef SINGLE_STEP_EN
    input  logic               step_mode,
    input  logic               step,
`endif
    output logic [IMEM_AW-1:0] PC,
    output logic [2:0]         Read_Addr_A,
    output logic [2:0]         Read_Addr_B,
    output logic [2:0]         Write_Addr,
    output logic               Write_En,
    output logic               Pre_C,
    output logic               Src_ALU_B,
    output logic               ADC,
    output logic               SUB,
    output logic               SBB,
    output logic [4:0]         imm5,
    output logic [3:0]         Flags,
    output logic               Halted
);

    state_t state;

    logic [2:0]  dec_ra, dec_rb, dec_rd;
    logic [4:0]  dec_imm;
    logic        dec_alu, dec_addi, dec_adc, dec_sub, dec_sbb;
    logic        dec_bz, dec_bnz, dec_bc, dec_bn, dec_jmp, dec_halt;
    logic [7:0]  dec_br_off;
    logic [10:0] dec_jmp_off;

    logic              run_active;
    logic              step_ok;
    logic              exec_en;
    logic              taken;
    logic [IMEM_AW-1:0] next_pc;

    instr_decode u_decode (
        .instr   (Instr),
        .ra      (dec_ra),
        .rb      (dec_rb),
        .rd      (dec_rd),
        .imm     (dec_imm),
        .alu_op  (dec_alu),
        .addi_op (dec_addi),
        .adc     (dec_adc),
        .sub     (dec_sub),
        .sbb     (dec_sbb),
        .br_z    (dec_bz),
        .br_nz   (dec_bnz),
        .br_c    (dec_bc),
        .br_n    (dec_bn),
        .jmp_op  (dec_jmp),
        .halt_op (dec_halt),
        .br_off  (dec_br_off),
        .jmp_off (dec_jmp_off)
    );

`ifdef SINGLE_STEP_EN
    logic step_prev;

    // A step executes only on a rising edge of step, seen against last cycle's sample.
    always_ff @(posedge clk) begin
        if (clr) step_prev <= 1'b0;
        else     step_prev <= step;
    end

    assign step_ok = !step_mode || (step && !step_prev);
`else
    assign step_ok = 1'b1;
`endif

    assign run_active = (state == ST_RUN);
    assign exec_en    = run_active && step_ok;
    assign Pre_C      = Flags[1];

    assign taken = (dec_bz  &&  Flags[3]) ||
                   (dec_bnz && !Flags[3]) ||
                   (dec_bc  &&  Flags[1]) ||
                   (dec_bn  &&  Flags[2]);

    // Offsets are truncated to the PC width, so all arithmetic wraps naturally.
    always_comb begin
        next_pc = PC + IMEM_AW'(1);
        if (dec_jmp)
            next_pc = next_pc + IMEM_AW'(sext11(dec_jmp_off));
        else if (taken)
            next_pc = next_pc + IMEM_AW'(sext8(dec_br_off));
    end

    always_comb begin
        Read_Addr_A = run_active ? dec_ra  : 3'd0;
        Read_Addr_B = run_active ? dec_rb  : 3'd0;
        Write_Addr  = run_active ? dec_rd  : 3'd0;
        imm5        = run_active ? dec_imm : 5'd0;
        Src_ALU_B   = run_active && dec_addi;
        ADC         = run_active && dec_adc;
        SUB         = run_active && dec_sub;
        SBB         = run_active && dec_sbb;
        Write_En    = exec_en && (dec_alu || dec_addi);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            PC     <= '0;
            Flags  <= 4'd0;
            state  <= ST_RST;
            Halted <= 1'b0;
        end else begin
            case (state)
                ST_RST: state <= ST_RUN;
                ST_RUN: begin
                    if (exec_en) begin
                        if (dec_halt) begin
                            state  <= ST_HALT;
                            Halted <= 1'b1;
                        end else begin
                            PC <= next_pc;
                        end
                        if (dec_alu || dec_addi)
                            Flags <= {Z, N, C, V};
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_fetch_decode.sv
// Self-checking bench for ctrl_fetch_decode: directed scenarios plus random
// instruction streams checked against an architectural model (PC/flags/halt).
module tb_ctrl_fetch_decode;

    localparam int AW     = 8;
    localparam int PC_MOD = 1 << AW;

    logic          clk = 1'b0;
    logic          clr;
    logic [15:0]   Instr;
    logic          Z, N, C, V;
    logic [AW-1:0] PC;
    logic [2:0]    Read_Addr_A, Read_Addr_B, Write_Addr;
    logic          Write_En, Pre_C, Src_ALU_B, ADC, SUB, SBB;
    logic [4:0]    imm5;
    logic [3:0]    Flags;
    logic          Halted;
`ifdef SINGLE_STEP_EN
    logic          stepMode = 1'b0;
    logic          stepSig  = 1'b0;
`endif

    always #5 clk = ~clk;

    ctrl_fetch_decode #(.IMEM_AW(AW)) dut (
        .clk         (clk),
        .clr         (clr),
        .Instr       (Instr),
        .Z           (Z),
        .N           (N),
        .C           (C),
        .V           (V),
`ifdef SINGLE_STEP_EN
        .step_mode   (stepMode),
        .step        (stepSig),
`endif
        .PC          (PC),
        .Read_Addr_A (Read_Addr_A),
        .Read_Addr_B (Read_Addr_B),
        .Write_Addr  (Write_Addr),
        .Write_En    (Write_En),
        .Pre_C       (Pre_C),
        .Src_ALU_B   (Src_ALU_B),
        .ADC         (ADC),
        .SUB         (SUB),
        .SBB         (SBB),
        .imm5        (imm5),
        .Flags       (Flags),
        .Halted      (Halted)
    );

    int total = 0;
    int bad   = 0;

    // Architectural model: program counter, flag word, halted, and whether the
    // next cycle is the dead cycle that follows a reset.
    int          mPc;
    logic [3:0]  mFlags;
    bit          mHalted;
    bit          mFresh;
    bit          mKnown = 1'b0;
    bit          mStepPrev = 1'b0;
    logic [15:0] curIns;
    logic [3:0]  curFl;
    bit          curRst;
    bit          curExec;
    int          startPc;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int wrapMod(input int x, input int m);
        return ((x % m) + m) % m;
    endfunction

    function automatic int sx8(input logic [7:0] b);
        return b[7] ? int'(b) - 256 : int'(b);
    endfunction

    function automatic int sx11(input logic [10:0] b);
        return b[10] ? int'(b) - 2048 : int'(b);
    endfunction

    function automatic logic [15:0] nopIns();
        logic [10:0] r;
        r = 11'($urandom);
        return {5'b01101, r};
    endfunction

    function automatic logic [15:0] addIns();
        logic [10:0] r;
        r = 11'($urandom);
        return {5'b00000, r};
    endfunction

    task automatic applyStimulus(input logic [15:0] ins, input logic [3:0] fl, input bit rst);
        Instr  = ins;
        {Z, N, C, V} = fl;
        clr    = rst;
        curIns = ins;
        curFl  = fl;
        curRst = rst;
    endtask

    // Drive one cycle's inputs and check the combinational control outputs.
    task automatic preEdge(input logic [15:0] ins, input logic [3:0] fl, input bit rst);
        int op;
        bit active, stepOk, isAlu, isAddi;
        applyStimulus(ins, fl, rst);
        #1;
        op     = int'(ins[15:11]);
        stepOk = 1'b1;
`ifdef SINGLE_STEP_EN
        stepOk = !stepMode || (stepSig && !mStepPrev);
`endif
        active  = mKnown && !mFresh && !mHalted;
        curExec = active && stepOk;
        isAlu   = (op <= 3);
        isAddi  = (op == 4);
        if (mKnown) begin
            checkOutput("read_a",  32'(Read_Addr_A), (active && (isAlu || isAddi)) ? 32'(ins[7:5])  : 32'd0);
            checkOutput("read_b",  32'(Read_Addr_B), (active && isAlu)             ? 32'(ins[4:2])  : 32'd0);
            checkOutput("wr_addr", 32'(Write_Addr),  (active && (isAlu || isAddi)) ? 32'(ins[10:8]) : 32'd0);
            checkOutput("imm5",    32'(imm5),        (active && isAddi)            ? 32'(ins[4:0])  : 32'd0);
            checkOutput("wr_en",   32'(Write_En),    32'(curExec && (isAlu || isAddi)));
            checkOutput("src_b",   32'(Src_ALU_B),   32'(active && isAddi));
            checkOutput("adc",     32'(ADC),         32'(active && op == 1));
            checkOutput("sub",     32'(SUB),         32'(active && op == 2));
            checkOutput("sbb",     32'(SBB),         32'(active && op == 3));
            checkOutput("pre_c",   32'(Pre_C),       32'(mFlags[1]));
        end
    endtask

    // Clock the cycle, advance the model, and check the registered state.
    task automatic postEdge();
        int op;
        @(posedge clk);
        #1;
        op = int'(curIns[15:11]);
        if (curRst) begin
            mPc     = 0;
            mFlags  = 4'd0;
            mHalted = 1'b0;
            mFresh  = 1'b1;
            mKnown  = 1'b1;
        end else if (mKnown) begin
            if (mFresh) begin
                mFresh = 1'b0;
            end else if (!mHalted && curExec) begin
                case (op)
                    0, 1, 2, 3, 4: begin
                        mFlags = curFl;
                        mPc    = wrapMod(mPc + 1, PC_MOD);
                    end
                    8:  mPc = wrapMod(mPc + 1 + (mFlags[3]  ? sx8(curIns[7:0]) : 0), PC_MOD);
                    9:  mPc = wrapMod(mPc + 1 + (!mFlags[3] ? sx8(curIns[7:0]) : 0), PC_MOD);
                    10: mPc = wrapMod(mPc + 1 + (mFlags[1]  ? sx8(curIns[7:0]) : 0), PC_MOD);
                    11: mPc = wrapMod(mPc + 1 + (mFlags[2]  ? sx8(curIns[7:0]) : 0), PC_MOD);
                    12: mPc = wrapMod(mPc + 1 + sx11(curIns[10:0]), PC_MOD);
                    31: mHalted = 1'b1;
                    default: mPc = wrapMod(mPc + 1, PC_MOD);
                endcase
            end
        end
`ifdef SINGLE_STEP_EN
        mStepPrev = curRst ? 1'b0 : stepSig;
`endif
        if (mKnown) begin
            checkOutput("pc",     32'(PC),     32'(mPc));
            checkOutput("flags",  32'(Flags),  32'(mFlags));
            checkOutput("halted", 32'(Halted), 32'(mHalted));
        end
    endtask

    task automatic runCycle(input logic [15:0] ins, input logic [3:0] fl, input bit rst);
        preEdge(ins, fl, rst);
        postEdge();
    endtask

    task automatic gotoPc(input int target);
        logic [10:0] off;
        off = 11'(wrapMod(target - mPc - 1, 2048));
        runCycle({5'b01100, off}, 4'($urandom), 1'b0);
    endtask

    initial begin
        clr   = 1'b1;
        Instr = 16'd0;
        {Z, N, C, V} = 4'd0;

        // Reset held for five cycles, then the dead RST cycle and first RUN cycle.
        for (int i = 0; i < 5; i++) runCycle(16'($urandom), 4'($urandom), 1'b1);
        runCycle(addIns(), 4'b1111, 1'b0);
        checkOutput("run_pc0", 32'(PC), 32'd0);
        runCycle(nopIns(), 4'($urandom), 1'b0);
        checkOutput("second_edge_pc1", 32'(PC), 32'd1);

        // ADC decode and carry capture into the flag register.
        preEdge(16'h0A24, 4'b0010, 1'b0);
        checkOutput("adc_ra", 32'(Read_Addr_A), 32'd1);
        checkOutput("adc_rb", 32'(Read_Addr_B), 32'd1);
        checkOutput("adc_rd", 32'(Write_Addr),  32'd2);
        checkOutput("adc_bit", 32'(ADC),        32'd1);
        checkOutput("adc_we", 32'(Write_En),    32'd1);
        postEdge();
        checkOutput("adc_flag_c", 32'(Flags[1]), 32'd1);
        checkOutput("adc_pre_c",  32'(Pre_C),    32'd1);

        // BZ taken and not taken from PC 0x10 with offset -2.
        runCycle(addIns(), 4'b1000, 1'b0);
        gotoPc(16);
        checkOutput("goto_10", 32'(PC), 32'h10);
        runCycle({5'b01000, 3'b000, 8'hFE}, 4'($urandom), 1'b0);
        checkOutput("bz_taken", 32'(PC), 32'h0F);
        runCycle(addIns(), 4'b0000, 1'b0);
        gotoPc(16);
        runCycle({5'b01000, 3'b000, 8'hFE}, 4'($urandom), 1'b0);
        checkOutput("bz_not_taken", 32'(PC), 32'h11);

        // PC wrap on sequential step and on a -1 jump.
        gotoPc(255);
        runCycle(nopIns(), 4'($urandom), 1'b0);
        checkOutput("wrap_nop", 32'(PC), 32'h00);
        runCycle({5'b01100, 11'h7FF}, 4'($urandom), 1'b0);
        checkOutput("wrap_jmp", 32'(PC), 32'h00);

        // Random instruction stream (no HALT) with occasional resets in flight.
        for (int i = 0; i < 300; i++) begin
            logic [4:0] op;
            logic [10:0] rest;
            case ($urandom_range(0, 3))
                0:       op = 5'($urandom_range(0, 4));
                1:       op = 5'($urandom_range(8, 12));
                default: op = 5'($urandom_range(0, 30));
            endcase
            rest = 11'($urandom);
            runCycle({op, rest}, 4'($urandom), ($urandom_range(0, 49) == 0));
        end
        runCycle(nopIns(), 4'($urandom), 1'b0);
        runCycle(nopIns(), 4'($urandom), 1'b0);

        // HALT freezes the PC and suppresses writes until clr.
        gotoPc(5);
        runCycle(16'hF800, 4'($urandom), 1'b0);
        checkOutput("halt_flag", 32'(Halted), 32'd1);
        checkOutput("halt_pc",   32'(PC),     32'd5);
        for (int i = 0; i < 10; i++) begin
            preEdge(addIns(), 4'($urandom), 1'b0);
            checkOutput("halt_we", 32'(Write_En), 32'd0);
            postEdge();
            checkOutput("halt_hold_pc", 32'(PC), 32'd5);
        end
        runCycle(nopIns(), 4'($urandom), 1'b1);
        checkOutput("clr_pc",     32'(PC),     32'd0);
        checkOutput("clr_halted", 32'(Halted), 32'd0);

`ifdef SINGLE_STEP_EN
        // Step held high for several cycles advances exactly one instruction.
        runCycle(nopIns(), 4'($urandom), 1'b0);
        stepMode = 1'b1;
        stepSig  = 1'b0;
        runCycle(addIns(), 4'($urandom), 1'b0);
        startPc = int'(PC);
        stepSig = 1'b1;
        for (int i = 0; i < 4; i++) runCycle(addIns(), 4'($urandom), 1'b0);
        checkOutput("single_step", 32'(PC), 32'(wrapMod(startPc + 1, PC_MOD)));
        stepSig  = 1'b0;
        stepMode = 1'b0;
        runCycle(nopIns(), 4'($urandom), 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
